instr_decode_queue: RTL

Parametrised successor to the combinational field decoder. It buffers fetched instructions in a DEPTH-entry queue with valid/ready handshakes on both sides and presents registered, fully split MIPS fields (plus PC and instruction class) to the execute/control stage. It sits between instruction fetch and the control unit. It supports pipeline stall via backpressure and a synchronous flush for branch/jump redirects.

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/instr_fifo.sv | 57 +++++
 rtl/instr_decode_queue.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, instruction class encodings,
// instruction-word field positions and a small classification helper.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;

   localparam logic [1:0] ITYPE_R = 2'b00;
   localparam logic [1:0] ITYPE_I = 2'b01;
   localparam logic [1:0] ITYPE_J = 2'b10;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_MSB  = 10;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;
   localparam int IMM_MSB    = 15;
   localparam int ADDR_MSB   = 25;

   // Instruction class from the opcode alone.
   function automatic logic [1:0] classify(input logic [5:0] op);
      if (op == OP_RTYPE)
         return ITYPE_R;
      else if (op == OP_J || op == OP_JAL)
         return ITYPE_J;
      else
         return ITYPE_I;
   endfunction

   // True when the immediate should be sign-extended; the logical
   // immediates are always zero-extended.
   function automatic logic immIsSigned(input logic [5:0] op, input logic signExtEn);
      return signExtEn && !(op == OP_ANDI || op == OP_ORI || op == OP_XORI);
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular buffer of DEPTH entries holding {instruction, PC} pairs.
// Pointers wrap naturally (DEPTH is a power of two); count tells full from
// empty. The caller never pushes when full nor pops when empty.
module instr_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [AW:0]   count
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [AW:0]   r_count;

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push)
         r_mem[r_wrPtr] <= wdata;
   end

   // Pointer and occupancy tracking; flush empties the buffer in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (push)
            r_wrPtr <= r_wrPtr + 1'b1;
         if (pop)
            r_rdPtr <= r_rdPtr + 1'b1;
         if (push && !pop)
            r_count <= r_count + 1'b1;
         else if (pop && !push)
            r_count <= r_count - 1'b1;
      end
   end

   assign rdata = r_mem[r_rdPtr];
   assign count = r_count;

endmodule

// File: rtl/instr_decode_queue.sv
// Instruction decode queue: buffers fetched instructions in instr_fifo and
// presents registered MIPS fields, PC and instruction class downstream.
// Build option DECODE_SIGNEXT_EN: when defined imm_ext is sign-extended
// (except ANDI/ORI/XORI); otherwise imm_ext is always zero-extended.
module instr_decode_queue
   import mips_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int EXT_W = 32,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [PC_W-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [5:0]       opcode,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [4:0]       shamt,
   output logic [5:0]       funct,
   output logic [15:0]      imm16,
   output logic [25:0]      address,
   output logic [EXT_W-1:0] imm_ext,
   output logic [PC_W-1:0]  pc_out,
   output logic [1:0]       itype,
   output logic [CNT_W-1:0] count
);

`ifdef DECODE_SIGNEXT_EN
   localparam logic SIGNEXT_EN = 1'b1;
`else
   localparam logic SIGNEXT_EN = 1'b0;
`endif

   logic [CNT_W-1:0]   w_count;
   logic [31+PC_W:0]   w_head;
   logic               w_fifoEmpty;
   logic               w_accept;
   logic               w_take;
   logic               w_load;
   logic               w_pop;
   logic               w_push;
   logic               w_bypass;
   logic [31:0]        w_srcInstr;
   logic [PC_W-1:0]    w_srcPc;
   logic [15:0]        w_srcImm;
   logic [EXT_W-1:0]   w_srcImmExt;

   logic               r_outValid;
   logic [31:0]        r_instr;
   logic [PC_W-1:0]    r_pc;
   logic [1:0]         r_itype;
   logic [EXT_W-1:0]   r_immExt;

   instr_fifo #(
      .DEPTH (DEPTH),
      .W     (32 + PC_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (w_push),
      .pop   (w_pop),
      .wdata ({in_pc, in_instr}),
      .rdata (w_head),
      .count (w_count)
   );

   // Handshake and steering: output register refills from the queue head
   // first, or directly from fetch when the queue is empty.
   always_comb begin
      in_ready    = rst_n && !flush && (w_count < CNT_W'(DEPTH));
      w_accept    = in_valid && in_ready;
      w_take      = r_outValid && out_ready;
      w_load      = !r_outValid || w_take;
      w_fifoEmpty = (w_count == '0);
      w_pop       = w_load && !w_fifoEmpty && !flush;
      w_bypass    = w_load && w_fifoEmpty && w_accept;
      w_push      = w_accept && !w_bypass;
      w_srcInstr  = w_fifoEmpty ? in_instr : w_head[31:0];
      w_srcPc     = w_fifoEmpty ? in_pc    : w_head[31+PC_W:32];
      w_srcImm    = w_srcInstr[IMM_MSB:0];
      if (immIsSigned(w_srcInstr[OPCODE_MSB:OPCODE_LSB], SIGNEXT_EN))
         w_srcImmExt = EXT_W'(signed'(w_srcImm));
      else
         w_srcImmExt = EXT_W'(w_srcImm);
   end

   // Output register: flush drops the valid flag but keeps field values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outValid <= 1'b0;
         r_instr    <= '0;
         r_pc       <= '0;
         r_itype    <= '0;
         r_immExt   <= '0;
      end else if (flush) begin
         r_outValid <= 1'b0;
      end else if (w_load) begin
         if (!w_fifoEmpty || w_accept) begin
            r_outValid <= 1'b1;
            r_instr    <= w_srcInstr;
            r_pc       <= w_srcPc;
            r_itype    <= classify(w_srcInstr[OPCODE_MSB:OPCODE_LSB]);
            r_immExt   <= w_srcImmExt;
         end else begin
            r_outValid <= 1'b0;
         end
      end
   end

   assign out_valid = r_outValid;
   assign opcode    = r_instr[OPCODE_MSB:OPCODE_LSB];
   assign rs        = r_instr[RS_MSB:RS_LSB];
   assign rt        = r_instr[RT_MSB:RT_LSB];
   assign rd        = r_instr[RD_MSB:RD_LSB];
   assign shamt     = r_instr[SHAMT_MSB:SHAMT_LSB];
   assign funct     = r_instr[FUNCT_MSB:FUNCT_LSB];
   assign imm16     = r_instr[IMM_MSB:0];
   assign address   = r_instr[ADDR_MSB:0];
   assign imm_ext   = r_immExt;
   assign pc_out    = r_pc;
   assign itype     = r_itype;
   assign count     = w_count;

endmodule
